fb_mem_responder: RTL and testbench
===================================

# fb_mem_responder

Memory-side responder for the FBCPU bus: a 64×10 RAM that answers the CPU's MAR/RAMWr/MDRIn/MDROut accesses with one-cycle registered reads and synchronous writes. It also owns program loading. A host streams a program into RAM over a valid/ready port while the block holds the CPU in reset, then releases it. CPU writes to a reserved address are mirrored to a memory-mapped output register that drives board LEDs.

## Interface
Parameters:
- ADDRESS_WIDTH, 6, CPU/loader address width
- DATA_WIDTH, 10, word width
- DEPTH, 64, number of words (2**ADDRESS_WIDTH)
- IO_ADDR, 63, address whose CPU writes also update io_out

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- MAR  in  ADDRESS_WIDTH  CPU access address
- RAMWr  in  1  CPU write strobe
- MDRIn  in  DATA_WIDTH  CPU write data
- MDROut  out  DATA_WIDTH  read data to CPU (registered)
- cpu_rst  out  1  reset to CPU; high whenever state != RUN
- ld_start  in  1  begin (re)load from address 0
- ld_valid  in  1  loader word valid
- ld_data  in  DATA_WIDTH  loader word
- ld_last  in  1  qualifies final word of program
- ld_ready  out  1  block accepts a loader word this cycle
- ld_count  out  ADDRESS_WIDTH+1  words written in current/last load (0..64)
- io_out  out  DATA_WIDTH  last CPU write to IO_ADDR
- state  out  2  IDLE=0, LOAD=1, RUN=2

## Operation
- Reset: state=IDLE, MDROut=0, io_out=0, ld_count=0, load pointer=0, ld_ready=0, cpu_rst=1. RAM contents are not cleared.
- cpu_rst and ld_ready are combinational from the state register: cpu_rst=(state!=RUN), ld_ready=(state==LOAD).
- IDLE:
  - ld_start -> LOAD; pointer and ld_count cleared.
  - CPU port ignored; MDROut holds its value.
- LOAD:
  - On ld_valid&ld_ready: mem[ptr]<=ld_data, ptr++, ld_count++.
  - Exits to RUN after accepting a word with ld_last=1, or after accepting the word at ptr=DEPTH-1, whichever comes first. The pointer never wraps; no word beyond 64 is ever written.
  - ld_start in LOAD restarts: ptr=0, ld_count=0, no write that cycle even if ld_valid.
  - RAMWr ignored; MDROut forced to 0.
- RUN:
  - Every cycle MDROut<=mem[MAR].
  - If RAMWr: mem[MAR]<=MDRIn. If additionally MAR==IO_ADDR, io_out<=MDRIn.
  - Read and write to the same address in one cycle: MDROut returns the old data (read-first).
  - ld_start -> LOAD; the CPU is reset from the next cycle and that cycle's CPU write is still performed.
  - ld_valid and ld_last are ignored.
- ld_valid/ld_last/ld_data in IDLE are ignored.
- ld_start takes priority over ld_valid in every state.
- rst takes priority over everything. A load interrupted by rst leaves the already-written words in RAM, ld_count=0, state=IDLE.
- Address/data widths are exact; MAR values are always in range (DEPTH=2**ADDRESS_WIDTH).

## Timing
- Read latency 1: MAR presented in cycle N, MDROut valid throughout cycle N+1. This matches CPU fetch (MAR in durum 0, IR latched in durum 1) and operand read (durum 2 → 3).
- Write: RAMWr/MAR/MDRIn sampled at the posedge ending the cycle; data is readable with MAR presented in the next cycle.
- io_out updates at the same edge as the RAM write.
- Loader handshake: a word is transferred at a posedge where ld_valid&ld_ready=1. ld_data is held by the host until transferred.
- Final word transferred at edge E: state=RUN and cpu_rst=0 from cycle E+1. The CPU starts fetch at PC=0 on edge E+1.
- ld_start sampled at edge E: state=LOAD and cpu_rst=1 from cycle E+1.

## Test plan
- Load 3 words 0x040, 0x241, 0x200 (ld_last on the third), then hold ld_valid: exactly 3 writes, ld_count=3, cpu_rst falls the cycle after the third transfer, and mem[0..2] reads back correctly.
- Stream 70 words without ld_last: only 64 are accepted, ld_ready drops after the 64th, ld_count=64, state=RUN, and mem[63] holds word 63.
- In RUN, MAR=5 with mem[5]=0x155: MDROut=0x155 one cycle later. Write 0x0AA to 5 while reading 5: MDROut=0x155 that read, 0x0AA on the next.
- CPU write MAR=63, MDRIn=0x3FF: io_out=0x3FF next cycle. Write to MAR=62: io_out unchanged.
- ld_start during RUN: cpu_rst=1 next cycle, state=LOAD, ld_count=0, and the CPU write issued in the same cycle still lands in RAM.
- rst after 2 of 5 loader words: state=IDLE, ld_ready=0, io_out=0, MDROut=0, and mem[0..1] retain the loaded words.

Source files
------------

// File: rtl/fb_mem_responder.sv
// fb_mem_responder: FBCPU RAM with host program loader, CPU reset control and mirrored LED output register.
module fb_mem_responder #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int DEPTH         = 64,
  parameter int IO_ADDR       = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic                     RAMWr,
  input  logic [DATA_WIDTH-1:0]    MDRIn,
  output logic [DATA_WIDTH-1:0]    MDROut,
  output logic                     cpu_rst,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic [ADDRESS_WIDTH:0]   ld_count,
  output logic [DATA_WIDTH-1:0]    io_out,
  output logic [1:0]               state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
  localparam logic [ADDRESS_WIDTH:0]   LAST_PTR = (ADDRESS_WIDTH+1)'(DEPTH-1);
  localparam logic [ADDRESS_WIDTH-1:0] IO_A     = ADDRESS_WIDTH'(IO_ADDR);
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    mdr_q, mdr_d, io_q, io_d, wdata;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic                     we;
  // The word count doubles as the load pointer; it stops at DEPTH so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdr_d   = mdr_q;
    io_d    = io_q;
    we      = 1'b0;
    waddr   = MAR;
    wdata   = MDRIn;
    if (ld_start) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else if (state_q == LOAD && ld_valid) begin
      we      = 1'b1;
      waddr   = cnt_q[ADDRESS_WIDTH-1:0];
      wdata   = ld_data;
      cnt_d   = cnt_q + 1'b1;
      state_d = (ld_last || cnt_q == LAST_PTR) ? RUN : LOAD;
    end
    if (state_q == RUN) begin
      mdr_d = mem[MAR];
      we    = RAMWr;
      io_d  = (RAMWr && MAR == IO_A) ? MDRIn : io_q;
    end
    mdr_d = (state_q == LOAD) ? '0 : mdr_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mdr_q   <= '0;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      io_q    <= io_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end
  assign MDROut   = mdr_q;
  assign io_out   = io_q;
  assign ld_count = cnt_q;
  assign state    = state_q;
  assign cpu_rst  = (state_q != RUN);
  assign ld_ready = (state_q == LOAD);
endmodule

// File: tb/tb_fb_mem_responder.sv
// tb_fb_mem_responder: directed checks of loading, RUN-mode access, IO mirror and reset behaviour.
module tb_fb_mem_responder;
  logic       clk = 1'b0;
  logic       rst, RAMWr, cpu_rst, ld_start, ld_valid, ld_last, ld_ready;
  logic [5:0] MAR;
  logic [9:0] MDRIn, MDROut, ld_data, io_out;
  logic [6:0] ld_count;
  logic [1:0] state;
  int         n_cmp = 0;
  int         n_bad = 0;
  fb_mem_responder dut (
    .clk(clk), .rst(rst), .MAR(MAR), .RAMWr(RAMWr), .MDRIn(MDRIn), .MDROut(MDROut),
    .cpu_rst(cpu_rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_count(ld_count), .io_out(io_out), .state(state)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; RAMWr = 0; MAR = 0; MDRIn = 0; ld_start = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_mdr", 32'(MDROut), 0);
    chk("rst_io", 32'(io_out), 0);
    chk("rst_cnt", 32'(ld_count), 0);
    chk("rst_ready", 32'(ld_ready), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    rst = 0; ld_valid = 1; ld_data = 10'h155;
    tick();
    chk("idle_ignore_valid", 32'(ld_count), 0);
    chk("idle_state", 32'(state), 0);
    ld_valid = 0; ld_start = 1;
    tick();
    chk("start_state", 32'(state), 1);
    chk("start_ready", 32'(ld_ready), 1);
    ld_start = 0; ld_valid = 1; ld_data = 10'h040;
    tick();
    chk("ld1_cnt", 32'(ld_count), 1);
    ld_data = 10'h241;
    tick();
    chk("ld2_cpu_rst", 32'(cpu_rst), 1);
    ld_data = 10'h200; ld_last = 1;
    tick();
    chk("ld3_cnt", 32'(ld_count), 3);
    chk("ld3_state", 32'(state), 2);
    chk("ld3_cpu_rst", 32'(cpu_rst), 0);
    ld_last = 0; ld_data = 10'h3FF;
    tick();
    chk("ld_hold_cnt", 32'(ld_count), 3);
    chk("ld_hold_ready", 32'(ld_ready), 0);
    ld_valid = 0; MAR = 0;
    tick();
    chk("rd_mem0", 32'(MDROut), 32'h040);
    MAR = 1;
    tick();
    chk("rd_mem1", 32'(MDROut), 32'h241);
    MAR = 2;
    tick();
    chk("rd_mem2", 32'(MDROut), 32'h200);
    ld_start = 1;
    tick();
    ld_start = 0;
    chk("ovf_cnt0", 32'(ld_count), 0);
    for (int i = 0; i < 70; i++) begin
      ld_valid = 1; ld_data = 10'(32'h100 + i);
      tick();
      if (i == 62) chk("ovf_ready63", 32'(ld_ready), 1);
      if (i == 63) chk("ovf_ready64", 32'(ld_ready), 0);
    end
    ld_valid = 0;
    chk("ovf_cnt", 32'(ld_count), 64);
    chk("ovf_state", 32'(state), 2);
    MAR = 63;
    tick();
    chk("ovf_mem63", 32'(MDROut), 32'h13F);
    MAR = 0;
    tick();
    chk("ovf_no_wrap", 32'(MDROut), 32'h100);
    MAR = 5; MDRIn = 10'h155; RAMWr = 1;
    tick();
    RAMWr = 0;
    tick();
    chk("rd5", 32'(MDROut), 32'h155);
    RAMWr = 1; MDRIn = 10'h0AA;
    tick();
    chk("rd5_read_first", 32'(MDROut), 32'h155);
    RAMWr = 0;
    tick();
    chk("rd5_new", 32'(MDROut), 32'h0AA);
    MAR = 63; MDRIn = 10'h3FF; RAMWr = 1;
    tick();
    chk("io_write", 32'(io_out), 32'h3FF);
    MAR = 62; MDRIn = 10'h011;
    tick();
    chk("io_hold", 32'(io_out), 32'h3FF);
    MAR = 10; MDRIn = 10'h2AB; RAMWr = 1; ld_start = 1;
    tick();
    chk("rl_state", 32'(state), 1);
    chk("rl_cpu_rst", 32'(cpu_rst), 1);
    chk("rl_cnt", 32'(ld_count), 0);
    RAMWr = 0; ld_start = 0;
    tick();
    chk("rl_mdr_zero", 32'(MDROut), 0);
    ld_valid = 1; ld_last = 1; ld_data = 10'h001;
    tick();
    ld_valid = 0; ld_last = 0;
    chk("rl_run", 32'(state), 2);
    tick();
    chk("rl_write_landed", 32'(MDROut), 32'h2AB);
    ld_start = 1;
    tick();
    ld_start = 0; ld_valid = 1; ld_data = 10'h0C1;
    tick();
    ld_data = 10'h0C2;
    tick();
    chk("ri_cnt2", 32'(ld_count), 2);
    rst = 1; ld_data = 10'h0C3;
    tick();
    rst = 0; ld_valid = 0;
    chk("ri_state", 32'(state), 0);
    chk("ri_ready", 32'(ld_ready), 0);
    chk("ri_io", 32'(io_out), 0);
    chk("ri_mdr", 32'(MDROut), 0);
    chk("ri_cnt", 32'(ld_count), 0);
    ld_start = 1;
    tick();
    ld_start = 0; ld_valid = 1; ld_last = 1; ld_data = 10'h0C1;
    tick();
    ld_valid = 0; ld_last = 0; MAR = 1;
    tick();
    chk("ri_mem1", 32'(MDROut), 32'h0C2);
    MAR = 2;
    tick();
    chk("ri_mem2_no_write", 32'(MDROut), 32'h102);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
